alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation per request: latch operands, wait out multi-cycle ops, capture result.
// Optional zero-result flag and port are enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int MULTI_LAT  = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req,
    output logic                    ready,
    input  logic [DATA_WIDTH-1:0]   a_in,
    input  logic [DATA_WIDTH-1:0]   b_in,
    input  logic [3:0]              op_in,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [3:0]              alu_op,
    input  logic [2*DATA_WIDTH-1:0] alu_result,
    output logic [DATA_WIDTH-1:0]   z_hi,
    output logic [DATA_WIDTH-1:0]   z_lo,
    output logic                    done
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic                    zero
`endif
);

    localparam int CNT_W = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 1);
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [3:0] OP_DIV = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT,
        CAPTURE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [3:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   z_hi_q, z_hi_d;
    logic [DATA_WIDTH-1:0]   z_lo_q, z_lo_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic                    zero_q, zero_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        z_hi_d  = z_hi_q;
        z_lo_d  = z_lo_q;
        done_d  = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    op_d    = op_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_q == OP_MUL || op_q == OP_DIV) begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end else begin
                    state_d = CAPTURE;
                end
            end
            WAIT: begin
                // Counter is checked before decrementing, so MULTI_LAT WAIT edges elapse.
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                z_hi_d  = alu_result[2*DATA_WIDTH-1:DATA_WIDTH];
                z_lo_d  = alu_result[DATA_WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                zero_d  = (alu_result == '0);
`endif
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            z_hi_q  <= '0;
            z_lo_q  <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            z_hi_q  <= z_hi_d;
            z_lo_q  <= z_lo_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign ready  = ready_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;
    assign z_hi   = z_hi_q;
    assign z_lo   = z_lo_q;
    assign done   = done_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU; zero-flag checks need ALU_SEQ_ZERO_FLAG_EN.
module tb_alu_sequencer;

    localparam int DW = 32;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req;
    logic          ready;
    logic [DW-1:0] a_in, b_in;
    logic [3:0]    op_in;
    logic [DW-1:0] alu_a, alu_b;
    logic [3:0]    alu_op;
    logic [2*DW-1:0] alu_result;
    logic [DW-1:0] z_hi, z_lo;
    logic          done;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic          zero;
`endif

    typedef struct {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_WIDTH(DW), .MULTI_LAT(ML)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .ready      (ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .op_in      (op_in),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .z_hi       (z_hi),
        .z_lo       (z_lo),
        .done       (done)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .zero       (zero)
`endif
    );

    // Behavioural ALU driven by the sequencer's operand outputs.
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = {{DW{1'b0}}, alu_a | alu_b};
            4'd1:    alu_result = {{DW{1'b0}}, alu_a & alu_b};
            4'd2:    alu_result = {{DW{1'b0}}, alu_a + alu_b};
            4'd12:   alu_result = (2*DW)'(alu_a) * (2*DW)'(alu_b);
            4'd13:   alu_result = (alu_b == '0) ? '1 : {alu_a % alu_b, alu_a / alu_b};
            default: alu_result = {alu_b, alu_a};
        endcase
    end

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 1'b0;
        a_in    = '0;
        b_in    = '0;
        op_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (z_hi !== '0 || z_lo !== '0) begin n_err++; $display("FAIL reset_z got=%h_%h exp=0", z_hi, z_lo); end
        n_cmp++; if (alu_op !== 4'd0 || alu_a !== '0 || alu_b !== '0) begin
            n_err++; $display("FAIL reset_operands got op=%h a=%h b=%h exp=0", alu_op, alu_a, alu_b);
        end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b exp=0", zero); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got=%b exp=1", ready); end
    endtask

    task automatic test_single();
        logic [3:0]    ops[3] = '{4'd0, 4'd2, 4'd14};
        logic [DW-1:0] as[3]  = '{32'h0000_00F0, 32'h0000_0005, 32'h0000_0011};
        logic [DW-1:0] bs[3]  = '{32'h0000_000F, 32'h0000_0007, 32'h0000_0022};
        exp_t          ex[3]  = '{'{32'h0, 32'h0000_00FF}, '{32'h0, 32'h0000_000C}, '{32'h0000_0022, 32'h0000_0011}};
        for (int i = 0; i < 3; i++) begin
            int   edges = 0;
            bit   got = 0;
            bit   op_bad = 0;
            exp_t e;
            req = 1'b1; op_in = ops[i]; a_in = as[i]; b_in = bs[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            req = 1'b0;
            n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL single_busy[%0d] ready=%b exp=0", i, ready); end
            while (edges < 20 && !got) begin
                if (alu_op !== ops[i] || alu_a !== as[i] || alu_b !== bs[i]) op_bad = 1;
                @(posedge clk); #1;
                edges++;
                if (done === 1'b1) got = 1;
            end
            n_cmp++; if (!got || edges != 2) begin n_err++; $display("FAIL single_latency[%0d] got=%0d exp=2 (seen=%0d)", i, edges, got); end
            n_cmp++; if (op_bad) begin n_err++; $display("FAIL single_operands[%0d] unstable got=1 exp=0", i); end
            e = sb.pop_front();
            n_cmp++; if (z_hi !== e.hi || z_lo !== e.lo) begin
                n_err++; $display("FAIL single_result[%0d] got=%h_%h exp=%h_%h", i, z_hi, z_lo, e.hi, e.lo);
            end
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b0 || z_hi !== e.hi || z_lo !== e.lo) begin
                n_err++; $display("FAIL single_hold[%0d] done=%b z=%h_%h exp done=0 z=%h_%h", i, done, z_hi, z_lo, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_multi();
        logic [3:0]    ops[2] = '{4'd12, 4'd13};
        logic [DW-1:0] as[2]  = '{32'h0001_0000, 32'd100};
        logic [DW-1:0] bs[2]  = '{32'h0001_0000, 32'd7};
        exp_t          ex[2]  = '{'{32'h0000_0001, 32'h0}, '{32'd2, 32'd14}};
        for (int i = 0; i < 2; i++) begin
            int   edges = 0;
            bit   got = 0;
            bit   rdy_bad = 0;
            exp_t e;
            req = 1'b1; op_in = ops[i]; a_in = as[i]; b_in = bs[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            req = 1'b0;
            while (edges < 40 && !got) begin
                if (ready !== 1'b0) rdy_bad = 1;
                @(posedge clk); #1;
                edges++;
                if (done === 1'b1) got = 1;
            end
            n_cmp++; if (!got || edges != ML + 2) begin n_err++; $display("FAIL multi_latency[%0d] got=%0d exp=%0d (seen=%0d)", i, edges, ML + 2, got); end
            n_cmp++; if (rdy_bad) begin n_err++; $display("FAIL multi_ready[%0d] ready high while busy got=1 exp=0", i); end
            e = sb.pop_front();
            n_cmp++; if (z_hi !== e.hi || z_lo !== e.lo) begin
                n_err++; $display("FAIL multi_result[%0d] got=%h_%h exp=%h_%h", i, z_hi, z_lo, e.hi, e.lo);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy();
        int   edges = 0;
        int   extra = 0;
        bit   got = 0;
        bit   op_bad = 0;
        exp_t e;
        req = 1'b1; op_in = 4'd12; a_in = 32'd3; b_in = 32'd5;
        sb.push_back('{32'h0, 32'd15});
        @(posedge clk); #1;
        req = 1'b0;
        while (edges < 40 && !got) begin
            if (alu_op !== 4'd12 || alu_a !== 32'd3 || alu_b !== 32'd5) op_bad = 1;
            @(posedge clk); #1;
            edges++;
            if (edges == 2) begin req = 1'b1; op_in = 4'd1; a_in = '0; b_in = '0; end
            if (edges == 3) req = 1'b0;
            if (done === 1'b1) got = 1;
        end
        n_cmp++; if (!got || edges != ML + 2) begin n_err++; $display("FAIL busy_latency got=%0d exp=%0d (seen=%0d)", edges, ML + 2, got); end
        n_cmp++; if (op_bad) begin n_err++; $display("FAIL busy_op_stable changed got=1 exp=0"); end
        e = sb.pop_front();
        n_cmp++; if (z_hi !== e.hi || z_lo !== e.lo) begin
            n_err++; $display("FAIL busy_result got=%h_%h exp=%h_%h", z_hi, z_lo, e.hi, e.lo);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        n_cmp++; if (extra != 0) begin n_err++; $display("FAIL busy_extra_done got=%0d exp=0", extra); end
        n_cmp++; if (alu_op !== 4'd12) begin n_err++; $display("FAIL busy_op_hold got=%h exp=c", alu_op); end
    endtask

    task automatic test_midreset();
        int dones = 0;
        req = 1'b1; op_in = 4'd13; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (z_hi !== '0 || z_lo !== '0 || done !== 1'b0 || ready !== 1'b1) begin
            n_err++; $display("FAIL midreset_async got z=%h_%h done=%b ready=%b exp z=0 done=0 ready=1", z_hi, z_lo, done, ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready got=%b exp=1", ready); end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
        n_cmp++; if (z_hi !== '0 || z_lo !== '0) begin n_err++; $display("FAIL midreset_z got=%h_%h exp=0", z_hi, z_lo); end
    endtask

    task automatic test_back_to_back();
        int   d1 = -1;
        int   d2 = -1;
        exp_t e;
        req = 1'b1; op_in = 4'd0; a_in = 32'hF0F0_00FF; b_in = 32'h0FF0_0F0F;
        sb.push_back('{32'h0, 32'hFFF0_0FFF});
        @(posedge clk); #1;
        op_in = 4'd1;
        sb.push_back('{32'h0, 32'h00F0_000F});
        for (int edge_n = 1; edge_n <= 12; edge_n++) begin
            @(posedge clk); #1;
            if (edge_n == 3) begin
                n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept ready=%b exp=0", ready); end
                req = 1'b0;
            end
            if (done === 1'b1) begin
                if (d1 < 0) d1 = edge_n; else if (d2 < 0) d2 = edge_n;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_cmp++; if (z_hi !== e.hi || z_lo !== e.lo) begin
                        n_err++; $display("FAIL b2b_result at %0d got=%h_%h exp=%h_%h", edge_n, z_hi, z_lo, e.hi, e.lo);
                    end
                end
            end
        end
        n_cmp++; if (d1 != 2) begin n_err++; $display("FAIL b2b_first_done edge got=%0d exp=2", d1); end
        n_cmp++; if (d2 != 5) begin n_err++; $display("FAIL b2b_second_done edge got=%0d exp=5", d2); end
    endtask

`ifdef ALU_SEQ_ZERO_FLAG_EN
    task automatic test_zero();
        logic [3:0] ops[2] = '{4'd1, 4'd0};
        logic       ez[2]  = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            int edges = 0;
            bit got = 0;
            req = 1'b1; op_in = ops[i]; a_in = 32'hFFFF_0000; b_in = 32'h0000_FFFF;
            @(posedge clk); #1;
            req = 1'b0;
            while (edges < 20 && !got) begin
                @(posedge clk); #1;
                edges++;
                if (done === 1'b1) got = 1;
            end
            n_cmp++; if (!got || zero !== ez[i]) begin n_err++; $display("FAIL zero_flag[%0d] got=%b exp=%b (seen=%0d)", i, zero, ez[i], got); end
            @(posedge clk); #1;
            n_cmp++; if (zero !== ez[i]) begin n_err++; $display("FAIL zero_hold[%0d] got=%b exp=%b", i, zero, ez[i]); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_busy();
        test_midreset();
        test_back_to_back();
`ifdef ALU_SEQ_ZERO_FLAG_EN
        test_zero();
`endif
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
